// File: rtl/r88_pkg.sv
// Shared encodings for the Rocket88 register-transfer sequencer:
// command opcodes, register-select and address-select codes, FSM states.
package r88_pkg;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_IMM8  = 3'd1;
  localparam logic [2:0] OP_IMM16 = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_PULL  = 3'd4;

  localparam logic [3:0] RS_A     = 4'd0;
  localparam logic [3:0] RS_SP_H  = 4'd10;
  localparam logic [3:0] RS_FLAGS = 4'd11;

  localparam logic [1:0] AS_BC = 2'd0;
  localparam logic [1:0] AS_DD = 2'd1;
  localparam logic [1:0] AS_PC = 2'd2;
  localparam logic [1:0] AS_SP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SETUP,
    ST_ACCESS,
    ST_POST,
    ST_DONE
  } state_e;

  // High byte of a 16-bit pair lives in the next register code (wraps in 4 bits).
  function automatic logic [3:0] next_sel(input logic [3:0] sel);
    return sel + 4'd1;
  endfunction

endpackage

// File: rtl/r88_waitctr.sv
// Wait-state counter for one memory access; hit flags the final
// unacknowledged cycle the sequencer is allowed to hold a strobe.
module r88_waitctr #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign hit = en && (count == LAST);

endmodule

// File: rtl/r88_regseq.sv
// Rocket88 register-transfer sequencer: expands one decoder command into
// timed register-block controls and memory strobes.
module r88_regseq
  import r88_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       sysClock,
  input  logic       sysReset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [2:0] cmdOp,
  input  logic [3:0] cmdReg,
  output logic [3:0] regSel,
  output logic       regRead,
  output logic       regWrite,
  output logic [1:0] regAddrSel,
  output logic       incPC,
  output logic       spInc,
  output logic       spDec,
  output logic       memRead,
  output logic       memWrite,
  input  logic       memAck,
  output logic       opLatch,
  output logic       done,
  output logic       errFlag
);

  state_e     state, nxt;
  logic [2:0] op_r;
  logic [3:0] tgt_r;
  logic       hi_r;
  logic       err_r;
  logic       accept;
  logic       hit;
  logic       is_push;
  logic       is_stack;

  assign cmdReady = (state == ST_IDLE);
  assign accept   = cmdValid && cmdReady;
  assign is_push  = (op_r == OP_PUSH);
  assign is_stack = (op_r == OP_PUSH) || (op_r == OP_PULL);
  assign errFlag  = err_r;

  r88_waitctr #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_waitctr (
    .clk(sysClock),
    .rst(sysReset),
    .clr(state != ST_ACCESS),
    .en ((state == ST_ACCESS) && !memAck),
    .hit(hit)
  );

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      state <= ST_IDLE;
      hi_r  <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        hi_r  <= 1'b0;
        err_r <= 1'b0;
      end else begin
        if (state == ST_POST && op_r == OP_IMM16) hi_r <= 1'b1;
        if (state == ST_ACCESS && hit) err_r <= 1'b1;
      end
    end
  end

  // Command fields; the target advances to the high byte between IMM16 passes.
  always_ff @(posedge sysClock) begin
    if (accept) begin
      op_r  <= cmdOp;
      tgt_r <= cmdReg;
    end else if (state == ST_POST && op_r == OP_IMM16 && !hi_r) begin
      tgt_r <= next_sel(tgt_r);
    end
  end

  // Outputs are forced idle while reset is held so no strobe survives it.
  always_comb begin
    nxt        = state;
    regSel     = RS_A;
    regRead    = 1'b0;
    regWrite   = 1'b0;
    regAddrSel = AS_PC;
    incPC      = 1'b0;
    spInc      = 1'b0;
    spDec      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    opLatch    = 1'b0;
    done       = 1'b0;
    if (!sysReset) begin
      case (state)
        ST_IDLE: begin
          if (cmdValid) begin
            if (cmdOp > OP_PULL)       nxt = ST_DONE;
            else if (cmdOp == OP_PULL) nxt = ST_PRE;
            else                       nxt = ST_SETUP;
          end
        end
        ST_PRE: begin
          spInc = 1'b1;
          nxt   = ST_SETUP;
        end
        ST_SETUP: begin
          regAddrSel = is_stack ? AS_SP : AS_PC;
          if (is_push) begin
            regRead = 1'b1;
            regSel  = tgt_r;
          end
          nxt = ST_ACCESS;
        end
        ST_ACCESS: begin
          regAddrSel = is_stack ? AS_SP : AS_PC;
          if (is_push) begin
            memWrite = 1'b1;
            regRead  = 1'b1;
            regSel   = tgt_r;
          end else begin
            memRead = 1'b1;
          end
          if (memAck) begin
            if (op_r == OP_FETCH) begin
              opLatch = 1'b1;
            end else if (!is_push) begin
              regWrite = 1'b1;
              regSel   = tgt_r;
            end
            nxt = ST_POST;
          end else if (hit) begin
            nxt = ST_DONE;
          end
        end
        ST_POST: begin
          if (is_push)               spDec = 1'b1;
          else if (op_r != OP_PULL)  incPC = 1'b1;
          nxt = (op_r == OP_IMM16 && !hi_r) ? ST_SETUP : ST_DONE;
        end
        ST_DONE: begin
          done = 1'b1;
          nxt  = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r88_regseq.sv
// Scoreboard bench for r88_regseq: a timing model predicts each command's
// strobe events and access set-up; a monitor compares as the DUT emits them.
module tb_r88_regseq;

  localparam int T = 4;
  localparam int FETCH = 0, IMM8 = 1, IMM16 = 2, PUSH = 3, PULL = 4;
  localparam int EV_SPINC = 0, EV_OPL = 1, EV_RW = 2, EV_INCPC = 3, EV_SPDEC = 4, EV_DONE = 5;

  logic       sysClock = 1'b0;
  logic       sysReset = 1'b1;
  logic       cmdValid = 1'b0;
  logic [2:0] cmdOp    = 3'd0;
  logic [3:0] cmdReg   = 4'd0;
  logic       memAck   = 1'b0;
  logic       cmdReady, regRead, regWrite, incPC, spInc, spDec;
  logic       memRead, memWrite, opLatch, done, errFlag;
  logic [3:0] regSel;
  logic [1:0] regAddrSel;

  r88_regseq #(.ACK_TIMEOUT(T), .CNT_W(8)) dut (
    .sysClock(sysClock), .sysReset(sysReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdReg(cmdReg), .regSel(regSel), .regRead(regRead), .regWrite(regWrite),
    .regAddrSel(regAddrSel), .incPC(incPC), .spInc(spInc), .spDec(spDec), .memRead(memRead),
    .memWrite(memWrite), .memAck(memAck), .opLatch(opLatch), .done(done), .errFlag(errFlag)
  );

  always #5 sysClock = ~sysClock;

  typedef struct { int kind; int sel; int lat; int err; } ev_t;
  typedef struct { int as; bit push; int sel; } acc_t;

  ev_t  evq[$];
  acc_t accq[$];
  int   wq[$];
  bit   sb_en = 1'b1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int sel, input int lat, input int err);
    ev_t e;
    e.kind = kind; e.sel = sel; e.lat = lat; e.err = err;
    evq.push_back(e);
  endtask

  // Expected behaviour of one command: latencies counted from the accept edge.
  task automatic plan(input int op, input int rg, input int w1, input int w2);
    int t, w;
    acc_t a;
    if (op > PULL) begin
      push_ev(EV_DONE, 0, 1, 0);
      return;
    end
    t = 0;
    if (op == PULL) begin
      push_ev(EV_SPINC, 0, 1, 0);
      t = 1;
    end
    for (int p = 0; p < ((op == IMM16) ? 2 : 1); p++) begin
      w = (p == 0) ? w1 : w2;
      t = t + 1;
      a.as = (op == PUSH || op == PULL) ? 3 : 2;
      a.push = (op == PUSH);
      a.sel = (rg + p) % 16;
      accq.push_back(a);
      wq.push_back(w);
      if (w >= T) begin
        push_ev(EV_DONE, 0, t + T + 1, 1);
        return;
      end
      if (op == FETCH) push_ev(EV_OPL, 0, t + 1 + w, 0);
      else if (op != PUSH) push_ev(EV_RW, (rg + p) % 16, t + 1 + w, 0);
      if (op == PUSH) push_ev(EV_SPDEC, 0, t + 2 + w, 0);
      else if (op != PULL) push_ev(EV_INCPC, 0, t + 2 + w, 0);
      t = t + 2 + w;
    end
    push_ev(EV_DONE, 0, t + 1, 0);
  endtask

  // Memory model: acks after the planned number of wait cycles, random acks when idle.
  bit in_acc = 1'b0;
  int rc = 0, cw = 0;
  always @(negedge sysClock) begin
    if (memRead || memWrite) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        rc = 0;
        cw = (wq.size() > 0) ? wq.pop_front() : 0;
      end
      memAck = (rc == cw);
      rc++;
    end else begin
      in_acc = 1'b0;
      memAck = 1'($urandom_range(0, 1));
    end
  end

  int         cyc = 0, acc_cyc = -1000;
  bit         prev_strobe = 1'b0, err_next = 1'b0;
  logic [1:0] prev_as = 2'd2;
  logic       prev_rr = 1'b0;
  acc_t       cur;

  always @(negedge sysClock) begin
    int n, k;
    ev_t e;
    #1;
    cyc++;
    if (!sysReset) begin
      chk("exclusive_strobes", {30'd0, regRead & regWrite, memRead & memWrite}, 0);
      if (err_next) chk("err_cleared_on_accept", errFlag, 0);
      err_next = 1'b0;
      if (sb_en) begin
        n = int'(spInc) + int'(opLatch) + int'(regWrite) + int'(incPC) + int'(spDec) + int'(done);
        k = spInc ? EV_SPINC : opLatch ? EV_OPL : regWrite ? EV_RW : incPC ? EV_INCPC :
            spDec ? EV_SPDEC : EV_DONE;
        if (n > 1) chk("single_event", n, 1);
        else if (n == 1) begin
          if (evq.size() == 0) chk("unexpected_event", k, -1);
          else begin
            e = evq.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_latency", cyc - acc_cyc, e.lat);
            if (k == EV_RW) chk("write_sel", regSel, e.sel);
            if (k == EV_DONE) chk("done_err", errFlag, e.err);
          end
        end
        if (memRead || memWrite) begin
          if (!prev_strobe) begin
            if (accq.size() == 0) chk("unexpected_access", 1, 0);
            else begin
              cur = accq.pop_front();
              chk("setup_addr_sel", prev_as, cur.as);
              if (cur.push) chk("setup_reg_read", prev_rr, 1);
            end
          end
          chk("mem_direction", memWrite, cur.push);
          if (cur.push) chk("push_read_sel", {regRead, regSel}, {1'b1, 4'(cur.sel)});
        end
      end
      if (cmdValid && cmdReady) begin
        acc_cyc = cyc;
        err_next = 1'b1;
      end
    end
    prev_strobe = memRead || memWrite;
    prev_as = regAddrSel;
    prev_rr = regRead;
  end

  // Waits at a negedge for cmdReady (junk cmdValid while busy), then issues a command.
  task automatic issue(input int op, input int rg, input int w1, input int w2);
    int n = 0;
    while (!cmdReady && n < 200) begin
      cmdValid = 1'($urandom_range(0, 1));
      cmdOp = 3'($urandom);
      cmdReg = 4'($urandom);
      @(negedge sysClock);
      n++;
    end
    if (!cmdReady) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    plan(op, rg, w1, w2);
    cmdValid = 1'b1;
    cmdOp = 3'(op);
    cmdReg = 4'(rg);
    @(negedge sysClock);
    cmdValid = 1'($urandom_range(0, 1));
    cmdOp = 3'($urandom);
    cmdReg = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmdReady && n < 200) begin
      cmdValid = 1'($urandom_range(0, 1));
      @(negedge sysClock);
      n++;
    end
    cmdValid = 1'b0;
    chk("idle_reached", cmdReady, 1);
  endtask

  initial begin
    int op, rg, w1, w2, r, n;
    repeat (3) @(negedge sysClock);
    #2;
    chk("rst_ready", cmdReady, 1);
    chk("rst_addr_sel", regAddrSel, 2);
    chk("rst_outputs", {regSel, regRead, regWrite, incPC, spInc, spDec, memRead, memWrite,
                        opLatch, done, errFlag}, 0);
    @(negedge sysClock);
    sysReset = 1'b0;

    issue(FETCH, 0, 0, 0);
    issue(IMM16, 5, 2, 2);
    issue(PUSH, 0, 1, 0);
    issue(PULL, 2, 0, 0);
    issue(FETCH, 0, T + 2, 0);
    wait_idle();
    chk("err_sticky", errFlag, 1);
    issue(IMM8, 1, 0, 0);
    issue(6, 0, 0, 0);
    issue(IMM16, 9, 0, T);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 2) ? FETCH : (r == 2) ? IMM8 : (r == 3) ? IMM16 : (r < 6) ? PUSH :
           (r < 8) ? PULL : $urandom_range(5, 7);
      rg = (op == IMM16) ? 3 + 2 * $urandom_range(0, 3) : $urandom_range(0, 11);
      w1 = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 3);
      w2 = ($urandom_range(0, 7) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 3);
      issue(op, rg, w1, w2);
    end
    wait_idle();
    @(negedge sysClock);
    chk("events_drained", evq.size(), 0);
    chk("accesses_drained", accq.size(), 0);

    // Reset in the middle of a PUSH access.
    sb_en = 1'b0;
    wq.delete();
    wq.push_back(255);
    cmdValid = 1'b1;
    cmdOp = 3'(PUSH);
    cmdReg = 4'd0;
    n = 0;
    @(negedge sysClock);
    while (!memWrite && n < 10) begin
      @(negedge sysClock);
      n++;
    end
    chk("push_access_reached", memWrite, 1);
    sysReset = 1'b1;
    #2;
    chk("rst_drop_same_cycle", {memWrite, regRead}, 0);
    @(negedge sysClock);
    sysReset = 1'b0;
    cmdValid = 1'b0;
    #2;
    chk("rst_mid_ready", cmdReady, 1);
    chk("rst_mid_strobes", {memWrite, regRead, memRead, errFlag}, 0);

    repeat (3) @(negedge sysClock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/r88_regseq.md
Name: r88_regseq

Overview:
- Register-transfer sequencer for the Rocket88 register block.
- Accepts one-command-at-a-time requests from the instruction decoder and turns each into a timed sequence of register-block controls: regSel, regRead, regWrite, regAddrSel, incPC, plus new spInc/spDec strobes.
- Drives the external memory strobes alongside, so fetches, immediates and stack push/pull move bytes between memory and registers over intD without decoder involvement.

Parameters:
ACK_TIMEOUT, 16, max cycles memRead/memWrite held without memAck before abort (1..255)
CNT_W, 8, width of wait-state counter

Ports:
sysClock  input  1  system clock; all state on rising edge
sysReset  input  1  synchronous, active-high reset
cmdValid  input  1  decoder presents a command
cmdReady  output 1  sequencer idle and accepting
cmdOp     input  3  0=FETCH 1=IMM8 2=IMM16 3=PUSH 4=PULL; 5-7 reserved
cmdReg    input  4  target/source regSel code (0=A..10=SP_H, 11=flags)
regSel    output 4  to register block
regRead   output 1  register block drives intD
regWrite  output 1  register block captures intD
regAddrSel output 2  2=PC, 3=SP
incPC     output 1  one-cycle PC increment strobe
spInc     output 1  one-cycle SP increment strobe
spDec     output 1  one-cycle SP decrement strobe
memRead   output 1  memory read request, held until memAck
memWrite  output 1  memory write request, held until memAck
memAck    input  1  memory completes access this cycle
opLatch   output 1  FETCH byte on intD this cycle is the opcode
done      output 1  one-cycle completion pulse
errFlag   output 1  sticky timeout error, cleared on next accept

Behaviour:
- Reset: state IDLE; cmdReady=1; all other outputs 0; regSel=0; regAddrSel=2; counters 0.
- Handshake: command accepted on cycle where cmdValid & cmdReady. cmdOp/cmdReg latched. cmdReady=0 from the next cycle until the cycle after done. Reserved op: accepted, done pulses next cycle, no other strobes.
- Register block outputs are registered (1-cycle latency), so every access has a SETUP cycle.
- States: IDLE, PRE, SETUP, ACCESS, POST, DONE.
- PRE (PULL only): spInc=1 for one cycle, then SETUP.
- SETUP (1 cycle): regAddrSel = PC for FETCH/IMM8/IMM16, SP for PUSH/PULL. PUSH also sets regRead=1, regSel=cmdReg, so intD is valid in ACCESS.
- ACCESS: memRead (FETCH/IMM/PULL) or memWrite (PUSH) held every cycle until memAck.
  - PUSH: regRead held through ACCESS.
  - Read ops: on the memAck cycle, regWrite=1 with regSel = target for exactly that cycle. FETCH asserts opLatch instead of regWrite.
  - Wait counter increments each non-ack cycle. When it reaches ACK_TIMEOUT: drop strobes, errFlag=1, go to DONE, no register write.
- POST (1 cycle): incPC=1 for FETCH/IMM8/IMM16; spDec=1 for PUSH; nothing for PULL.
- IMM16: first pass writes cmdReg (low byte). POST then returns to SETUP with target cmdReg+1 (high byte), then POST again. Total: two PC increments.
- DONE: done=1 for one cycle, return to IDLE, cmdReady=1.
- Minimum latency, accept to done (memAck on first ACCESS cycle): FETCH/IMM8/PUSH 4 cycles, PULL 5, IMM16 7.
- Never assert regRead and regWrite together. Never assert memRead and memWrite together.
- memAck outside ACCESS is ignored.
- cmdValid while busy is ignored (no queuing).
- cmdReg+1 wraps within 4 bits. The decoder only issues IMM16 with low-half codes (3,5,7,9).
- sysReset mid-operation: immediate return to IDLE, strobes dropped the same cycle, errFlag cleared. No partial write is completed.

Decomposition:
- Shared package r88_pkg: cmdOp encodings (OP_FETCH..OP_PULL), regSel codes (RS_A..RS_FLAGS), regAddrSel codes (AS_BC, AS_DD, AS_PC, AS_SP), state encoding.
- One natural sub-module: r88_waitctr (wait-state counter with clear/enable and timeout compare). The FSM stays in r88_regseq.

Test Plan:
- FETCH, memAck on first ACCESS cycle, intD=8'hA9 -> regAddrSel=2 in SETUP; memRead 1 cycle; opLatch with intD=A9; incPC pulse; done 4 cycles after accept; no regWrite.
- IMM16 cmdReg=5 with memory bytes 34,12 and 2 wait states each -> regWrite regSel=5 (data 34), then regSel=6 (data 12); exactly two incPC pulses; done at cycle 11.
- PUSH cmdReg=0 (A) -> regRead from SETUP through ack; memWrite high until memAck; spDec pulse after ack; regWrite never high.
- PULL cmdReg=2 -> spInc first, then regAddrSel=3, memRead, regWrite regSel=2 on ack; no spDec/incPC; done at cycle 5.
- ACK_TIMEOUT=4, memAck never asserted -> memRead exactly 4 cycles then drops; errFlag=1; no regWrite; done pulse; next accept clears errFlag.
- sysReset asserted during ACCESS of PUSH -> next cycle memWrite=0, regRead=0, cmdReady=1; cmdValid held during busy ignored and accepted only after done.
